// File: rtl/vote_pkg.sv
// Shared voting-machine definitions: candidate count, front-end FSM
// states and a one-hot helper used by the button, count and display stages.
package vote_pkg;

  localparam int NUM_CAND = 4;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    WAIT_RELEASE,
    LOCKOUT
  } state_t;

  function automatic logic is_onehot(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/vote_sync.sv
// Parameterised-width two-flop synchroniser for asynchronous inputs,
// asynchronous active-low reset.
module vote_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vote_button_ctrl.sv
// Button front end: sync, hold qualification, release + lockout, one-hot pulse.
// Optional cand_vote_reject output when VOTE_REJECT_EN is defined.
module vote_button_ctrl #(
  parameter int NUM_CAND       = vote_pkg::NUM_CAND,
  parameter int HOLD_CYCLES    = 10,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode,
  input  logic [NUM_CAND-1:0] cand_button,
  output logic [NUM_CAND-1:0] cand_vote_valid,
  output logic                busy
`ifdef VOTE_REJECT_EN
  ,
  output logic                cand_vote_reject
`endif
);

  import vote_pkg::*;

  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int LW = $clog2(LOCKOUT_CYCLES) + 1;

  state_t              state;
  state_t              state_nxt;
  logic [NUM_CAND-1:0] s;
  logic [NUM_CAND-1:0] sel;
  logic [HW-1:0]       cnt;
  logic [LW-1:0]       lcnt;
  logic [NUM_CAND-1:0] valid_nxt;
  logic                s_one;
  logic                s_zero;
  logic                s_multi;
  logic                abort;
  logic                done;

  vote_sync #(
    .WIDTH(NUM_CAND)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (cand_button),
    .q    (s)
  );

  assign s_one   = is_onehot(32'(s));
  assign s_zero  = (s == '0);
  assign s_multi = !s_one && !s_zero;
  // mode beats a pulse landing in the same cycle
  assign abort   = mode || (s != sel);
  assign done    = (cnt == HW'(HOLD_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!mode && s_one)        state_nxt = COUNT;
        else if (!mode && s_multi) state_nxt = WAIT_RELEASE;
      end
      COUNT: begin
        if (abort)     state_nxt = s_zero ? IDLE : WAIT_RELEASE;
        else if (done) state_nxt = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (s_zero) state_nxt = LOCKOUT;
      end
      LOCKOUT: begin
        if (!s_zero)
          state_nxt = WAIT_RELEASE;
        else if (lcnt == LW'(LOCKOUT_CYCLES - 1))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    valid_nxt = '0;
    if (state == COUNT && !abort && done)
      valid_nxt = sel;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sel             <= '0;
      cnt             <= '0;
      lcnt            <= '0;
      cand_vote_valid <= '0;
    end else begin
      cand_vote_valid <= valid_nxt;
      if (state == IDLE && state_nxt == COUNT) begin
        sel <= s;
        cnt <= HW'(1);
      end
      if (state == COUNT && state_nxt == COUNT)
        cnt <= cnt + 1'b1;
      if (state == WAIT_RELEASE && state_nxt == LOCKOUT)
        lcnt <= '0;
      if (state == LOCKOUT && state_nxt == LOCKOUT)
        lcnt <= lcnt + 1'b1;
    end
  end

`ifdef VOTE_REJECT_EN
  logic extra;
  logic rej_nxt;

  assign extra   = |(s & ~sel);
  assign rej_nxt = !mode &&
                   ((state == IDLE && s_multi) ||
                    (state == COUNT && extra));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cand_vote_reject <= 1'b0;
    else        cand_vote_reject <= rej_nxt;
  end
`endif

endmodule

// File: tb/tb_vote_button_ctrl.sv
// Directed scenarios plus random button traffic against a run-length
// reference model of the vote front end.
module tb_vote_button_ctrl;

  localparam int H = 10;
  localparam int L = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       mode;
  logic [3:0] cand_button;
  logic [3:0] cand_vote_valid;
  logic       busy;
`ifdef VOTE_REJECT_EN
  logic       cand_vote_reject;
`endif

  vote_button_ctrl #(
    .NUM_CAND      (4),
    .HOLD_CYCLES   (H),
    .LOCKOUT_CYCLES(L)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .mode           (mode),
    .cand_button    (cand_button),
    .cand_vote_valid(cand_vote_valid),
    .busy           (busy)
`ifdef VOTE_REJECT_EN
    ,
    .cand_vote_reject(cand_vote_reject)
`endif
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;
  int edges;
  int pulse_edge;
  int npulse;
  int nrej;

  // Model: armed = a new press may start; quiet = consecutive idle samples
  bit         armed;
  bit         pressing;
  int         run;
  int         quiet;
  logic [3:0] sel_m;
  logic [3:0] sy1;
  logic [3:0] sy2;
  logic [3:0] ev;
  bit         er;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    armed = 1; pressing = 0; run = 0; quiet = 0;
    sel_m = '0; sy1 = '0; sy2 = '0; ev = '0; er = 0;
  endtask

  task automatic model_edge(input logic [3:0] b, input logic m);
    logic [3:0] s;
    s  = sy2;
    ev = '0;
    er = 0;
    if (pressing) begin
      if (m || s != sel_m) begin
        pressing = 0;
        er = !m && ((s & ~sel_m) != 0);
        if (s != 0) begin armed = 0; quiet = 0; end
      end else begin
        run++;
        if (run == H) begin
          ev = sel_m; pressing = 0; armed = 0; quiet = 0;
        end
      end
    end else if (!armed) begin
      if (s == 0) begin
        quiet++;
        if (quiet == L + 1) armed = 1;
      end else quiet = 0;
    end else if (!m && s != 0) begin
      if ($countones(s) == 1) begin
        pressing = 1; sel_m = s; run = 1;
      end else begin
        armed = 0; quiet = 0; er = 1;
      end
    end
    sy2 = sy1;
    sy1 = b;
  endtask

  task automatic step(input logic [3:0] b, input logic m);
    cand_button = b;
    mode = m;
    @(posedge clock);
    model_edge(b, m);
    #1;
    edges++;
    check("valid", cand_vote_valid, ev);
    check("busy", busy, pressing || !armed);
    if (cand_vote_valid != 0) begin
      npulse++;
      pulse_edge = edges;
    end
`ifdef VOTE_REJECT_EN
    check("reject", cand_vote_reject, er);
    if (cand_vote_reject) nrej++;
`endif
    @(negedge clock);
  endtask

  task automatic hold(input logic [3:0] b, input logic m, input int n);
    for (int i = 0; i < n; i++) step(b, m);
  endtask

  task automatic settle();
    hold(4'b0000, 1'b0, L + 4);
  endtask

  initial begin
    reset = 1'b0;
    mode = 1'b0;
    cand_button = '0;
    model_reset();
    repeat (3) @(negedge clock);
    check("reset_valid", cand_vote_valid, 0);
    check("reset_busy", busy, 0);
    reset = 1'b1;

    // clean press
    npulse = 0; edges = 0; pulse_edge = 0;
    hold(4'b0010, 1'b0, 20);
    check("clean_npulse", npulse, 1);
    check("clean_latency", pulse_edge, 12);
    edges = 0;
    for (int i = 0; i < 40; i++) begin
      step(4'b0000, 1'b0);
      if (!busy) break;
    end
    check("clean_busy_drop", edges, L + 3);

    // short press, then an immediate valid press
    npulse = 0;
    hold(4'b0001, 1'b0, 8);
    edges = 0;
    for (int i = 0; i < 10; i++) begin
      step(4'b0000, 1'b0);
      if (!busy) break;
    end
    check("short_npulse", npulse, 0);
    check("short_busy_drop", edges <= 3, 1);
    hold(4'b0100, 1'b0, 15);
    check("after_short_npulse", npulse, 1);
    settle();

    // multi-press, then a single press while waiting for release
    npulse = 0; nrej = 0;
    hold(4'b0101, 1'b0, 30);
    check("multi_npulse", npulse, 0);
`ifdef VOTE_REJECT_EN
    check("multi_nrej", nrej, 1);
`endif
    hold(4'b0100, 1'b0, 15);
    check("multi_repress_npulse", npulse, 0);
    settle();

    // lockout
    npulse = 0;
    hold(4'b1000, 1'b0, 15);
    hold(4'b0000, 1'b0, 5);
    hold(4'b1000, 1'b0, 15);
    check("lockout_npulse", npulse, 1);
    hold(4'b0000, 1'b0, L + 3);
    check("lockout_idle", busy, 0);
    hold(4'b1000, 1'b0, 15);
    check("lockout_accept", npulse, 2);
    settle();

    // mode inhibit and mode abort mid-hold
    npulse = 0;
    hold(4'b0010, 1'b1, 20);
    hold(4'b0000, 1'b1, 4);
    check("mode_npulse", npulse, 0);
    hold(4'b0010, 1'b0, 7);
    step(4'b0010, 1'b1);
    hold(4'b0010, 1'b0, 15);
    check("mode_abort_npulse", npulse, 0);
    check("mode_abort_busy", busy, 1);
    settle();

    // async reset while a pulse is in flight
    hold(4'b0001, 1'b0, 12);
    check("pre_reset_valid", cand_vote_valid, 4'b0001);
    #2 reset = 1'b0;
    #1;
    check("async_valid", cand_vote_valid, 0);
    check("async_busy", busy, 0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    npulse = 0; edges = 0; pulse_edge = 0;
    hold(4'b0001, 1'b0, 20);
    check("post_reset_npulse", npulse, 1);
    check("post_reset_latency", pulse_edge, 12);
    settle();

    // random traffic
    for (int k = 0; k < 150; k++) begin
      logic [3:0] pat;
      logic       md;
      int         r;
      r = $urandom_range(0, 3);
      if (r == 0)      pat = 4'b0000;
      else if (r == 2) pat = 4'($urandom_range(0, 15));
      else             pat = 4'b0001 << $urandom_range(0, 3);
      md = ($urandom_range(0, 9) == 0);
      hold(pat, md, $urandom_range(1, 25));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vote_button_ctrl.md
Name: vote_button_ctrl

Overview:
- Front-end stage of the voting machine. It takes raw candidate push-buttons and produces clean single-cycle, one-hot vote-valid pulses for the vote-counting stage directly downstream.
- Each button is synchronised, then must be held long enough to count. Multi-button presses are rejected.
- The voter must release all buttons, and a lockout window must expire, before another vote is accepted.
- While mode=1 (result/display mode), no votes are generated.

Parameters:
- NUM_CAND, 4, number of candidates; width of button and valid vectors.
- HOLD_CYCLES, 10, consecutive synchronised-high cycles required to accept a press (≥2).
- LOCKOUT_CYCLES, 16, idle cycles enforced after the all-released condition before the next vote is accepted (≥1).

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- mode  input  1  0 = voting, 1 = result display (votes inhibited).
- cand_button  input  NUM_CAND  raw asynchronous buttons, 1 = pressed.
- cand_vote_valid  output  NUM_CAND  registered one-hot pulse, 1 cycle per accepted vote; bit i is candidate i+1.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counters=0, synchroniser flops=0, cand_vote_valid=0, busy=0.
- Synchronisation: each button passes through a 2-flop synchroniser. s denotes the synchronised vector. All decisions use s only.
- FSM states: IDLE, COUNT, WAIT_RELEASE, LOCKOUT.
- IDLE:
  - mode=0 and s one-hot → COUNT; sel<=s; cnt<=1.
  - mode=0 and s has ≥2 bits set → WAIT_RELEASE (reject, no vote).
  - Otherwise remain in IDLE.
- COUNT:
  - mode=1, or s≠sel (release, or an extra button pressed) → abort. Go to IDLE if s==0, else WAIT_RELEASE. No vote.
  - s==sel and cnt==HOLD_CYCLES-1 → cand_vote_valid<=sel for exactly one cycle; state<=WAIT_RELEASE.
  - Otherwise cnt<=cnt+1.
- WAIT_RELEASE: remain until s==0, then → LOCKOUT with lcnt<=0.
- LOCKOUT:
  - Any s≠0 → back to WAIT_RELEASE (a re-press restarts the release wait).
  - lcnt==LOCKOUT_CYCLES-1 → IDLE.
  - Otherwise lcnt++.
- Latency: if the first edge sampling the raw button high is edge 1, cand_vote_valid is high in the cycle after edge HOLD_CYCLES+2 (HOLD_CYCLES=10 → after edge 12).
- cand_vote_valid is never multi-hot. Exactly one pulse is produced per accepted press, regardless of how long the button is held.
- Counter widths are $clog2 of their parameter, +1 bit. No wrap is possible because each counter is bounded by its compare.
- mode is sampled directly without synchronisation; it is a synchronous system signal.
- If mode rises in the same cycle a pulse would be issued (COUNT, cnt==HOLD_CYCLES-1), the abort has priority and no pulse is issued.
- Reset mid-operation asynchronously returns to IDLE. Any in-flight pulse is cleared immediately.

Optional Feature:
- Macro: VOTE_REJECT_EN.
- Defined:
  - Adds output cand_vote_reject (1 bit), a registered single-cycle pulse.
  - Pulses on an IDLE→WAIT_RELEASE transition caused by a multi-press.
  - Pulses on a COUNT abort caused by an extra button pressed.
  - Does not pulse on plain early release, or on a mode-caused abort.
  - Reset value 0.
- Undefined: the port does not exist. Rejects are silent, and all other behaviour is identical.

Decomposition:
- Shared package vote_pkg:
  - NUM_CAND default constant.
  - FSM state enum: IDLE, COUNT, WAIT_RELEASE, LOCKOUT.
  - Helper function is_onehot.
  - Also used by the vote-counting and display stages.
- One sub-module: vote_sync, a parameterised-width 2-flop synchroniser with asynchronous active-low reset, instantiated once at width NUM_CAND.

Test Plan:
- Clean press: HOLD_CYCLES=10; raise cand_button=4'b0010 for 20 cycles, then release. cand_vote_valid=4'b0010 for exactly 1 cycle, after edge 12. busy returns to 0 LOCKOUT_CYCLES+3 cycles after release.
- Short press: hold 4'b0001 for 8 cycles, then release. No pulse. busy drops to 0 within 3 cycles of release. An immediate new valid press is accepted.
- Multi-press: raise 4'b0101 together and hold 30 cycles. No pulse. With VOTE_REJECT_EN, one reject pulse. A second press of 4'b0100 during WAIT_RELEASE yields no vote.
- Lockout: valid vote on 4'b1000, release, re-press 4'b1000 5 cycles later (LOCKOUT_CYCLES=16). No second pulse. After a full release plus 16 idle cycles, a press is accepted.
- Mode inhibit: mode=1, then press 4'b0010 for 20 cycles → no pulse. Assert mode at cnt==5 during a valid hold → no pulse, state goes to WAIT_RELEASE.
- Async reset: assert reset=0 mid-COUNT between clock edges. Outputs are 0 immediately. After release of reset with the button still held, a vote is produced only after a full new hold.
